// File: rtl/serial_pattern_generator.sv
// Serial pattern generator: emits a captured WIDTH-bit pattern MSB first, repeated with optional gaps.
// Define SERIAL_PATTERN_GENERATOR_PARITY_EN to append an even-parity bit to every repetition.
module serial_pattern_generator #(
    parameter int unsigned WIDTH      = 6,
    parameter int unsigned GAP_CYCLES = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pattern_valid,
    input  logic [WIDTH-1:0] pattern,
    input  logic [3:0]       repeat_cnt,
    output logic             pattern_ready,
    output logic             out_bit,
    output logic             out_valid,
    output logic             busy,
    output logic             done
);

    localparam int unsigned   IdxW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IdxW-1:0] IdxMsb = IdxW'(WIDTH - 1);
    localparam logic [3:0]    GapLoad = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;
    localparam bit            HasGap  = (GAP_CYCLES > 0);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StShift  = 2'd1,
`ifdef SERIAL_PATTERN_GENERATOR_PARITY_EN
        StGap    = 2'd2,
        StParity = 2'd3
`else
        StGap    = 2'd2
`endif
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pat_q, pat_d;
    logic [IdxW-1:0]  idx_q, idx_d;
    logic [3:0]       rep_q, rep_d;
    logic [3:0]       gap_q, gap_d;
    logic             end_rep;

    logic ready_q, ready_d;
    logic busy_q, busy_d;
    logic bit_q, bit_d;
    logic valid_q, valid_d;
    logic done_q, done_d;

    // Next-state: state_q names what is being emitted in the current cycle.
    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        idx_d   = idx_q;
        rep_d   = rep_q;
        gap_d   = gap_q;
        end_rep = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (pattern_valid && ready_q) begin
                    pat_d   = pattern;
                    rep_d   = (repeat_cnt == 4'd0) ? 4'd1 : repeat_cnt;
                    idx_d   = IdxMsb;
                    state_d = StShift;
                end
            end
            StShift: begin
                if (idx_q != '0) begin
                    idx_d = idx_q - 1'b1;
                end else begin
`ifdef SERIAL_PATTERN_GENERATOR_PARITY_EN
                    state_d = StParity;
`else
                    end_rep = 1'b1;
`endif
                end
            end
            StGap: begin
                if (gap_q == 4'd0) begin
                    state_d = StShift;
                    idx_d   = IdxMsb;
                end else begin
                    gap_d = gap_q - 4'd1;
                end
            end
`ifdef SERIAL_PATTERN_GENERATOR_PARITY_EN
            StParity: begin
                end_rep = 1'b1;
            end
`endif
            default: state_d = StIdle;
        endcase

        if (end_rep) begin
            if (rep_q > 4'd1) begin
                rep_d = rep_q - 4'd1;
                if (HasGap) begin
                    state_d = StGap;
                    gap_d   = GapLoad;
                end else begin
                    state_d = StShift;
                    idx_d   = IdxMsb;
                end
            end else begin
                state_d = StIdle;
            end
        end
    end

    // Outputs are derived from next state so that every port comes straight from a flop.
    always_comb begin
        ready_d = (state_d == StIdle);
        busy_d  = (state_d != StIdle);
        valid_d = 1'b0;
        bit_d   = 1'b0;
        done_d  = 1'b0;
        if (state_d == StShift) begin
            valid_d = 1'b1;
            bit_d   = pat_d[idx_d];
`ifndef SERIAL_PATTERN_GENERATOR_PARITY_EN
            done_d  = (idx_d == '0) && (rep_d == 4'd1);
`endif
        end
`ifdef SERIAL_PATTERN_GENERATOR_PARITY_EN
        if (state_d == StParity) begin
            valid_d = 1'b1;
            bit_d   = ^pat_q;
            done_d  = (rep_d == 4'd1);
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            pat_q   <= '0;
            idx_q   <= '0;
            rep_q   <= 4'd0;
            gap_q   <= 4'd0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            bit_q   <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            idx_q   <= idx_d;
            rep_q   <= rep_d;
            gap_q   <= gap_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            bit_q   <= bit_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    assign pattern_ready = ready_q;
    assign busy          = busy_q;
    assign out_bit       = bit_q;
    assign out_valid     = valid_q;
    assign done          = done_q;

endmodule

// File: tb/tb_serial_pattern_generator.sv
// Scoreboard bench for serial_pattern_generator (WIDTH=6, GAP_CYCLES=2); parity-aware via the same macro.
module tb_serial_pattern_generator;

    localparam int W   = 6;
    localparam int GAP = 2;
`ifdef SERIAL_PATTERN_GENERATOR_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int L = W + PAR;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         pattern_valid = 1'b0;
    logic [W-1:0] pattern = '0;
    logic [3:0]   repeat_cnt = 4'd0;
    logic         pattern_ready, out_bit, out_valid, busy, done;

    serial_pattern_generator #(
        .WIDTH      (W),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pattern_valid (pattern_valid),
        .pattern       (pattern),
        .repeat_cnt    (repeat_cnt),
        .pattern_ready (pattern_ready),
        .out_bit       (out_bit),
        .out_valid     (out_valid),
        .busy          (busy),
        .done          (done)
    );

    typedef struct {
        int   cyc;
        logic b;
        logic d;
    } bexp_t;

    typedef struct {
        int   cyc;
        logic rdy;
        logic bsy;
        logic vld;
        logic b;
        logic d;
        int   hits;
    } snap_t;

    bexp_t bq[$];
    snap_t sq[$];
    int    cyc = 0;
    int    n_vec = 0;
    int    n_miss = 0;
    int    nbits = 0;
    int    hits = 0;
    logic [5:0] det = 6'd0;
    bit    finish_req = 1'b0;

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog");
    end

    // Expected stream for one job whose handshake happens in cycle b.
    task automatic push_job(input logic [W-1:0] pat, input int rc, input int b, output int last);
        int   reps;
        int   c;
        logic p;
        reps = (rc == 0) ? 1 : rc;
        c    = b + 1;
        p    = ^pat;
        for (int r = 0; r < reps; r++) begin
            for (int i = W - 1; i >= 0; i--) begin
                bq.push_back('{cyc: c, b: pat[i], d: (r == reps - 1 && i == 0 && PAR == 0)});
                c++;
            end
            if (PAR != 0) begin
                bq.push_back('{cyc: c, b: p, d: (r == reps - 1)});
                c++;
            end
            if (r < reps - 1) c += GAP;
        end
        last = c - 1;
    endtask

    task automatic push_snap(input int c, input logic rdy, input logic bsy, input logic vld,
                             input logic b, input logic d, input int h);
        sq.push_back('{cyc: c, rdy: rdy, bsy: bsy, vld: vld, b: b, d: d, hits: h});
    endtask

    task automatic load(input logic [W-1:0] pat, input logic [3:0] rc, output int b,
                        output int last);
        pattern_valid = 1'b1;
        pattern       = pat;
        repeat_cnt    = rc;
        b             = cyc;
        push_job(pat, int'(rc), b, last);
        push_snap(b + 1, 1'b0, 1'b1, 1'b1, pat[W-1], 1'b0, -1);
        push_snap(last + 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        @(negedge clk);
        pattern_valid = 1'b0;
        pattern       = '0;
        repeat_cnt    = 4'd0;
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Stimulus
    initial begin
        int b, last, b2, last2;
        repeat (3) @(negedge clk);
        push_snap(cyc + 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single repetition; detector must fire exactly once.
        load(6'b110011, 4'd1, b, last);
        push_snap(last + 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        wait_cyc(last + 2);

        // Two repetitions separated by a gap.
        load(6'b110011, 4'd2, b, last);
        push_snap(b + L + 1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, -1);
        push_snap(b + L + 2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, -1);
        wait_cyc(last + 2);

        // repeat_cnt of zero behaves as one.
        load(6'b101010, 4'd0, b, last);
        wait_cyc(last + 2);

        // pattern_valid held through a job: second load on the first idle cycle.
        pattern_valid = 1'b1;
        pattern       = 6'b110011;
        repeat_cnt    = 4'd1;
        b             = cyc;
        push_job(6'b110011, 1, b, last);
        push_snap(b + 1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, -1);
        @(negedge clk);
        pattern    = 6'b000111;
        repeat_cnt = 4'd1;
        b2         = b + L + 1;
        push_job(6'b000111, 1, b2, last2);
        push_snap(b2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        push_snap(b2 + 1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, -1);
        push_snap(last2 + 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        wait_cyc(b2 + 1);
        pattern_valid = 1'b0;
        wait_cyc(last2 + 2);

        // Odd-weight pattern (parity bit 1 when enabled).
        load(6'b110111, 4'd1, b, last);
        wait_cyc(last + 2);

        // Three repetitions to exercise the counter past one decrement.
        load(6'b100001, 4'd3, b, last);
        wait_cyc(last + 2);

        // Reset in cycle 3 of a job, with a load request held during reset.
        pattern_valid = 1'b1;
        pattern       = 6'b110011;
        repeat_cnt    = 4'd1;
        b             = cyc;
        bq.push_back('{cyc: b + 1, b: 1'b1, d: 1'b0});
        bq.push_back('{cyc: b + 2, b: 1'b1, d: 1'b0});
        bq.push_back('{cyc: b + 3, b: 1'b0, d: 1'b0});
        push_snap(b + 1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, -1);
        @(negedge clk);
        pattern_valid = 1'b0;
        wait_cyc(b + 3);
        rst_n         = 1'b0;
        pattern_valid = 1'b1;
        pattern       = 6'b000111;
        repeat_cnt    = 4'd3;
        push_snap(b + 4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        push_snap(b + 5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        push_snap(b + 6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        push_snap(b + 9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        wait_cyc(b + 5);
        rst_n         = 1'b1;
        pattern_valid = 1'b0;
        wait_cyc(b + 11);

        finish_req = 1'b1;
    end

    // Monitor / scoreboard
    initial forever begin
        @(negedge clk);
        if (cyc >= 1) begin
            while (bq.size() > 0 && bq[0].cyc < cyc) begin
                n_vec++; n_miss++;
                $display("FAIL bit@%0d: got no valid bit, required bit=%b", bq[0].cyc, bq[0].b);
                bq.delete(0);
            end
            if (out_valid === 1'b1) begin
                nbits++;
                det = {det[4:0], out_bit};
                if (nbits >= 6 && det == 6'b110011) hits++;
                n_vec++;
                if (bq.size() == 0 || bq[0].cyc != cyc) begin
                    n_miss++;
                    $display("FAIL bit@%0d: got unexpected out_valid=1 bit=%b done=%b, required out_valid=0",
                             cyc, out_bit, done);
                end else begin
                    if (out_bit !== bq[0].b || done !== bq[0].d) begin
                        n_miss++;
                        $display("FAIL bit@%0d: got bit=%b done=%b, required bit=%b done=%b",
                                 cyc, out_bit, done, bq[0].b, bq[0].d);
                    end
                    bq.delete(0);
                end
            end else begin
                if (bq.size() > 0 && bq[0].cyc == cyc) begin
                    n_vec++; n_miss++;
                    $display("FAIL bit@%0d: got out_valid=%b, required valid bit=%b",
                             cyc, out_valid, bq[0].b);
                    bq.delete(0);
                end
                n_vec++;
                if (out_valid !== 1'b0 || out_bit !== 1'b0 || done !== 1'b0) begin
                    n_miss++;
                    $display("FAIL idle@%0d: got valid=%b bit=%b done=%b, required 0/0/0",
                             cyc, out_valid, out_bit, done);
                end
            end
            for (int i = 0; i < sq.size(); ) begin
                if (sq[i].cyc <= cyc) begin
                    n_vec++;
                    if (sq[i].cyc < cyc || pattern_ready !== sq[i].rdy || busy !== sq[i].bsy ||
                        out_valid !== sq[i].vld || out_bit !== sq[i].b || done !== sq[i].d ||
                        (sq[i].hits >= 0 && hits != sq[i].hits)) begin
                        n_miss++;
                        $display("FAIL status@%0d: got rdy=%b busy=%b vld=%b bit=%b done=%b hits=%0d, required rdy=%b busy=%b vld=%b bit=%b done=%b hits=%0d",
                                 sq[i].cyc, pattern_ready, busy, out_valid, out_bit, done, hits,
                                 sq[i].rdy, sq[i].bsy, sq[i].vld, sq[i].b, sq[i].d, sq[i].hits);
                    end
                    sq.delete(i);
                end else begin
                    i++;
                end
            end
            if (finish_req) begin
                if (bq.size() + sq.size() > 0) begin
                    n_vec++; n_miss++;
                    $display("FAIL leftover: got %0d unchecked expectations, required 0",
                             bq.size() + sq.size());
                end
                $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
                $finish;
            end
        end
    end

endmodule
